event_generator: RTL and testbench
==================================

# event_generator

Register-programmed, single-clock event pulse source: the transmit-side counterpart to the event counters. Software writes a pulse count and period over the standard memory bus, issues a start, and the block emits exactly that many one-cycle `event_active` pulses at the programmed spacing. It is used for self-test of counter channels and as a programmable stimulus source for downstream logic.

## Interface
- No parameters; all widths fixed at 32 bits.
- `clk` input 1: system clock; all logic is in this domain.
- `rst_n` input 1: asynchronous active-low reset.
- Memory slave port group: standard team memory-port macro, 32-bit data, byte offsets below.
- `event_active` output 1: registered one-cycle event pulse.
- `busy` output 1: high while a run is in progress.
- `done` output 1: sticky run-complete flag.
- `trigger` input 1: external start, present only with `EVENT_GENERATOR_TRIGGER_EN`.

## Operation
- Registers:
  - 0x00 CTRL: write bit0 start, bit1 stop, bit2 continuous, bit3 arm (trigger build only). Read returns bit0 busy, bit1 done, bit2 aborted, bit3 armed.
  - 0x04 COUNT (rw): pulses per run.
  - 0x08 PERIOD (rw): cycles from one pulse to the next.
  - 0x0C EMITTED (r): pulses emitted in the current or last run.
- COUNT, PERIOD, and the continuous bit are latched into working copies at start. Writes during a run affect only the next run.
- States:
  - IDLE → PULSE on start. If COUNT=0 and not continuous, IDLE → DONE instead, with no pulse.
  - PULSE: `event_active`=1 and EMITTED+1. If the final pulse (EMITTED+1 == COUNT, not continuous), go to DONE. Else if PERIOD ≤ 1, stay in PULSE. Else go to GAP with gap counter = PERIOD−2.
  - GAP: decrement the counter; at 0, go to PULSE.
  - DONE: set done, clear busy, go to IDLE.
- Start clears done, aborted, and EMITTED to 0. A start while busy is ignored.
- Stop in any non-IDLE state goes to IDLE next cycle. It sets aborted, leaves done clear, freezes EMITTED, and forces `event_active` low. If start and stop are written together, stop wins.
- In continuous mode COUNT is ignored. The run continues until stop, and EMITTED wraps from 0xFFFFFFFF to 0.
- PERIOD=0 is treated as 1.
- Reset values: `event_active`=0, `busy`=0, `done`=0, state IDLE, all registers 0, aborted and armed 0.

## Timing
- Start write accepted in cycle n: `busy` and `event_active` are high in cycle n+1.
- Pulse spacing is exactly max(PERIOD,1) cycles, rising edge to rising edge.
- After the final pulse in cycle m: `done`=1 and `busy`=0 from cycle m+2, and `busy` stays high through cycle m+1.
- Stop accepted in cycle n: `event_active`=0 and `busy`=0 from cycle n+1.
- Register read latency follows the standard memory-port rules. EMITTED as read reflects the pulse count as of the read-sampling cycle.
- Asynchronous reset mid-run drops `event_active` immediately. No partial pulse is counted after deassertion.

## Configuration
- `EVENT_GENERATOR_TRIGGER_EN` defined:
  - Adds the `trigger` port with a two-flop synchronizer and rising-edge detect.
  - Writing CTRL bit3 arms the block. The first synchronized rising edge while armed and idle acts as start and clears armed.
  - First pulse appears 4 cycles after the `trigger` rise: 2 synchronizer cycles, 1 edge-detect cycle, 1 FSM cycle.
  - Stop clears armed.
- Undefined: no `trigger` port, CTRL bit3 writes are ignored, and bit3 reads as 0.

## Test plan
- COUNT=5, PERIOD=4, start → exactly 5 one-cycle pulses, 4 cycles apart. First pulse 1 cycle after the write. Then EMITTED=5, done=1, busy=0.
- COUNT=3, PERIOD=0 → 3 consecutive high cycles. PERIOD=1 gives an identical waveform.
- COUNT=0, start → no pulse, done=1 two cycles later, EMITTED=0.
- Continuous, PERIOD=2, stop after 10 pulses → `event_active` low the next cycle, aborted=1, done=0, EMITTED=10. Start and stop in the same write → no pulse.
- Rewrite COUNT=7 mid-run of COUNT=2 → current run emits 2 pulses. Next start emits 7. Assert `rst_n` mid-pulse → all outputs are 0 immediately.
- Trigger build: arm, pulse `trigger` → first event 4 cycles after the rise. A second trigger without re-arm has no effect.

Source files
------------

// File: rtl/event_generator_if.sv
// -----------------------------------------------------------------------------
// event_generator_if
// Memory-mapped register bus used by event_generator.
//   req    : transfer request, qualified by we (1 = write, 0 = read)
//   we     : write enable
//   addr   : byte address (only 0x00..0x0C decode; word aligned)
//   wdata  : write data
//   rdata  : read data, valid the cycle after the read request
//   rvalid : one-cycle strobe marking rdata valid
// The slave is always ready: every request is accepted in the cycle it is
// presented.
// -----------------------------------------------------------------------------
interface event_generator_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rvalid;

  modport master (output req, we, addr, wdata, input rdata, rvalid);
  modport slave  (input req, we, addr, wdata, output rdata, rvalid);
endinterface

// File: rtl/event_generator.sv
// -----------------------------------------------------------------------------
// event_generator
// Register-programmed event pulse source. Software programs COUNT and PERIOD,
// issues a start through CTRL, and the block emits COUNT one-cycle pulses on
// event_active spaced PERIOD cycles apart (PERIOD 0 behaves as 1). Continuous
// mode runs until stopped.
//
// Ports
//   clk          : system clock
//   rst_n        : asynchronous active-low reset
//   bus          : register bus slave (event_generator_if.slave)
//   event_active : one-cycle event pulse
//   busy         : run in progress
//   done         : sticky run-complete flag, cleared by the next start
//   trigger      : external start (only with EVENT_GENERATOR_TRIGGER_EN)
//
// Registers (byte offsets)
//   0x00 CTRL    W: b0 start, b1 stop, b2 continuous, b3 arm
//                R: b0 busy, b1 done, b2 aborted, b3 armed
//   0x04 COUNT   RW pulses per run
//   0x08 PERIOD  RW cycles between pulse rising edges
//   0x0C EMITTED R  pulses emitted in the current or last run
//
// Build option: define EVENT_GENERATOR_TRIGGER_EN to add the trigger port,
// its synchronizer/edge detector and the arm bit. Without it, CTRL bit3 is
// ignored on write and reads as 0.
// -----------------------------------------------------------------------------
module event_generator (
  input  logic             clk,
  input  logic             rst_n,
  event_generator_if.slave bus,
  output logic             event_active,
  output logic             busy,
  output logic             done
`ifdef EVENT_GENERATOR_TRIGGER_EN
  ,
  input  logic             trigger
`endif
);

  // One-hot so event_active is a straight decode of a single state flop.
  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_PULSE = 4'b0010,
    S_GAP   = 4'b0100,
    S_DONE  = 4'b1000
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [31:0] r_count;
  logic [31:0] r_period;
  logic [31:0] r_wcount;
  logic [31:0] r_wperiod;
  logic        r_wcont;
  logic [31:0] r_gap;
  logic [31:0] r_emitted;
  logic        r_done;
  logic        r_aborted;
  logic [31:0] r_rdata;
  logic        r_rvalid;

  logic        w_addr_ok;
  logic        w_wr;
  logic        w_rd;
  logic        w_ctrl_wr;
  logic        w_stop_cmd;
  logic        w_sw_start;
  logic        w_idle;
  logic        w_trig_start;
  logic        w_start;
  logic        w_start_cont;
  logic        w_armed;
  logic [31:0] w_emitted_inc;
  logic        w_last;
  logic [31:0] w_rdata;

  // Only the four word-aligned offsets decode; anything else is ignored on
  // write and reads as zero.
  assign w_addr_ok  = (bus.addr[31:4] == 28'd0) && (bus.addr[1:0] == 2'b00);
  assign w_wr       = bus.req &  bus.we & w_addr_ok;
  assign w_rd       = bus.req & ~bus.we;
  assign w_ctrl_wr  = w_wr && (bus.addr[3:2] == 2'd0);
  assign w_stop_cmd = w_ctrl_wr & bus.wdata[1];
  // Stop wins over a simultaneous start.
  assign w_sw_start = w_ctrl_wr & bus.wdata[0] & ~bus.wdata[1];
  assign w_idle     = (r_state == S_IDLE);

`ifdef EVENT_GENERATOR_TRIGGER_EN
  logic r_sync1;
  logic r_sync2;
  logic r_sync3;
  logic r_trig_edge;
  logic r_armed;
  logic r_cont_cfg;

  assign w_trig_start = r_trig_edge & r_armed & w_idle & ~w_stop_cmd & ~w_sw_start;
  // A triggered run takes its continuous bit from the last CTRL write.
  assign w_start_cont = w_sw_start ? bus.wdata[2] : r_cont_cfg;
  assign w_armed      = r_armed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_sync3     <= 1'b0;
      r_trig_edge <= 1'b0;
      r_armed     <= 1'b0;
      r_cont_cfg  <= 1'b0;
    end else begin
      r_sync1     <= trigger;
      r_sync2     <= r_sync1;
      r_sync3     <= r_sync2;
      r_trig_edge <= r_sync2 & ~r_sync3;
      if (w_stop_cmd || w_trig_start) begin
        r_armed <= 1'b0;
      end else if (w_ctrl_wr && bus.wdata[3]) begin
        r_armed <= 1'b1;
      end
      if (w_ctrl_wr) begin
        r_cont_cfg <= bus.wdata[2];
      end
    end
  end
`else
  assign w_trig_start = 1'b0;
  assign w_start_cont = bus.wdata[2];
  assign w_armed      = 1'b0;
`endif

  // A start while busy is dropped here: only an idle block can start.
  assign w_start       = w_idle & (w_sw_start | w_trig_start);
  assign w_emitted_inc = r_emitted + 32'd1;
  assign w_last        = ~r_wcont && (w_emitted_inc == r_wcount);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_next = ((r_count == 32'd0) && !w_start_cont) ? S_DONE : S_PULSE;
        end
      end
      S_PULSE: begin
        if (w_stop_cmd) begin
          w_next = S_IDLE;
        end else if (w_last) begin
          w_next = S_DONE;
        end else if (r_wperiod < 32'd2) begin
          w_next = S_PULSE;
        end else begin
          w_next = S_GAP;
        end
      end
      S_GAP: begin
        if (w_stop_cmd) begin
          w_next = S_IDLE;
        end else if (r_gap == 32'd0) begin
          w_next = S_PULSE;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Output decode
  always_comb begin
    event_active = (r_state == S_PULSE);
    busy         = ~w_idle;
    done         = r_done;
  end

  // Register file, run bookkeeping and read port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count   <= 32'd0;
      r_period  <= 32'd0;
      r_wcount  <= 32'd0;
      r_wperiod <= 32'd0;
      r_wcont   <= 1'b0;
      r_gap     <= 32'd0;
      r_emitted <= 32'd0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      r_rdata   <= 32'd0;
      r_rvalid  <= 1'b0;
    end else begin
      if (w_wr && (bus.addr[3:2] == 2'd1)) r_count  <= bus.wdata;
      if (w_wr && (bus.addr[3:2] == 2'd2)) r_period <= bus.wdata;

      if (w_start) begin
        r_wcount  <= r_count;
        r_wperiod <= r_period;
        r_wcont   <= w_start_cont;
        r_emitted <= 32'd0;
        r_done    <= 1'b0;
        r_aborted <= 1'b0;
      end else begin
        // A pulse already on the output when stop lands is still counted;
        // continuous runs wrap naturally at 32 bits.
        if (r_state == S_PULSE) r_emitted <= w_emitted_inc;
        if (w_stop_cmd && !w_idle) r_aborted <= 1'b1;
        if ((r_state == S_DONE) && !w_stop_cmd) r_done <= 1'b1;
      end

      // Loaded on every pulse; only consumed when the next state is GAP,
      // which requires PERIOD >= 2, so the subtraction never underflows in use.
      if (r_state == S_PULSE) begin
        r_gap <= r_wperiod - 32'd2;
      end else if (r_state == S_GAP) begin
        r_gap <= r_gap - 32'd1;
      end

      r_rvalid <= w_rd;
      if (w_rd) r_rdata <= w_rdata;
    end
  end

  always_comb begin
    w_rdata = 32'd0;
    if (w_addr_ok) begin
      unique case (bus.addr[3:2])
        2'd0:    w_rdata = {28'd0, w_armed, r_aborted, r_done, busy};
        2'd1:    w_rdata = r_count;
        2'd2:    w_rdata = r_period;
        default: w_rdata = r_emitted;
      endcase
    end
  end

  assign bus.rdata  = r_rdata;
  assign bus.rvalid = r_rvalid;

endmodule

// File: tb/tb_event_generator.sv
// -----------------------------------------------------------------------------
// tb_event_generator
// Directed bench for event_generator. Bus transfers are presented on the
// falling edge and sampled by the DUT on the following rising edge; all DUT
// outputs are observed on falling edges. Sample 0 of a capture is the cycle
// directly after a start write is accepted.
// -----------------------------------------------------------------------------
module tb_event_generator;

  localparam logic [31:0] A_CTRL    = 32'h00;
  localparam logic [31:0] A_COUNT   = 32'h04;
  localparam logic [31:0] A_PERIOD  = 32'h08;
  localparam logic [31:0] A_EMITTED = 32'h0C;

  logic clk = 1'b0;
  logic rst_n;
  logic event_active;
  logic busy;
  logic done;
`ifdef EVENT_GENERATOR_TRIGGER_EN
  logic trigger;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  event_generator_if bus_if ();

  event_generator dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus_if),
    .event_active (event_active),
    .busy         (busy),
    .done         (done)
`ifdef EVENT_GENERATOR_TRIGGER_EN
    ,
    .trigger      (trigger)
`endif
  );

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    bus_if.req   = 1'b1;
    bus_if.we    = 1'b1;
    bus_if.addr  = a;
    bus_if.wdata = d;
    @(negedge clk);
    bus_if.req   = 1'b0;
    bus_if.we    = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic v);
    bus_if.req  = 1'b1;
    bus_if.we   = 1'b0;
    bus_if.addr = a;
    @(negedge clk);
    bus_if.req  = 1'b0;
    d = bus_if.rdata;
    v = bus_if.rvalid;
  endtask

  task automatic capture(input int n, output logic [31:0] ev, output logic [31:0] bz,
                         output logic [31:0] dn);
    ev = '0;
    bz = '0;
    dn = '0;
    for (int k = 0; k < n; k++) begin
      ev[k] = event_active;
      bz[k] = busy;
      dn[k] = done;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic        v;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({event_active, busy, done} !== 3'b000)
      $display("FAIL reset_outputs_held: got %b want 000", {event_active, busy, done});
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({event_active, busy, done} !== 3'b000)
      $display("FAIL reset_outputs_after: got %b want 000", {event_active, busy, done});
    else n_pass++;
    bus_read(A_CTRL, d, v);
    n_checks++;
    if (v !== 1'b1 || d !== 32'h0)
      $display("FAIL reset_ctrl: got %h valid %b want 00000000 valid 1", d, v);
    else n_pass++;
    bus_read(A_COUNT, d, v);
    n_checks++;
    if (d !== 32'h0) $display("FAIL reset_count: got %h want 00000000", d);
    else n_pass++;
    bus_read(A_PERIOD, d, v);
    n_checks++;
    if (d !== 32'h0) $display("FAIL reset_period: got %h want 00000000", d);
    else n_pass++;
    bus_read(A_EMITTED, d, v);
    n_checks++;
    if (d !== 32'h0) $display("FAIL reset_emitted: got %h want 00000000", d);
    else n_pass++;
  endtask

  task automatic test_arm_bit();
    logic [31:0] d;
    logic        v;
    bus_write(A_CTRL, 32'h8);
    bus_read(A_CTRL, d, v);
    n_checks++;
`ifdef EVENT_GENERATOR_TRIGGER_EN
    if (d !== 32'h8) $display("FAIL arm_readback: got %h want 00000008", d);
    else n_pass++;
    bus_write(A_CTRL, 32'h2);
    bus_read(A_CTRL, d, v);
    n_checks++;
    if (d !== 32'h0) $display("FAIL stop_clears_arm: got %h want 00000000", d);
    else n_pass++;
`else
    if (d !== 32'h0) $display("FAIL arm_ignored: got %h want 00000000", d);
    else n_pass++;
`endif
  endtask

  task automatic test_count5_period4();
    logic [31:0] ev, bz, dn, d;
    logic        v;
    bus_write(A_COUNT, 32'd5);
    bus_write(A_PERIOD, 32'd4);
    bus_write(A_CTRL, 32'h1);
    capture(32, ev, bz, dn);
    n_checks++;
    if (ev !== 32'h0001_1111) $display("FAIL c5p4_pulses: got %h want 00011111", ev);
    else n_pass++;
    n_checks++;
    if (bz !== 32'h0003_FFFF) $display("FAIL c5p4_busy: got %h want 0003ffff", bz);
    else n_pass++;
    n_checks++;
    if (dn !== 32'hFFFC_0000) $display("FAIL c5p4_done: got %h want fffc0000", dn);
    else n_pass++;
    bus_read(A_EMITTED, d, v);
    n_checks++;
    if (d !== 32'd5) $display("FAIL c5p4_emitted: got %0d want 5", d);
    else n_pass++;
    bus_read(A_CTRL, d, v);
    n_checks++;
    if (d !== 32'h2) $display("FAIL c5p4_ctrl: got %h want 00000002", d);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] ev, bz, dn;
    bus_write(A_COUNT, 32'd3);
    bus_write(A_PERIOD, 32'd0);
    bus_write(A_CTRL, 32'h1);
    capture(12, ev, bz, dn);
    n_checks++;
    if (ev !== 32'h7) $display("FAIL p0_pulses: got %h want 00000007", ev);
    else n_pass++;
    n_checks++;
    if (bz !== 32'hF) $display("FAIL p0_busy: got %h want 0000000f", bz);
    else n_pass++;
    n_checks++;
    if (dn !== 32'hFF0) $display("FAIL p0_done: got %h want 00000ff0", dn);
    else n_pass++;
    bus_write(A_PERIOD, 32'd1);
    bus_write(A_CTRL, 32'h1);
    capture(12, ev, bz, dn);
    n_checks++;
    if (ev !== 32'h7) $display("FAIL p1_pulses: got %h want 00000007", ev);
    else n_pass++;
    n_checks++;
    if (bz !== 32'hF) $display("FAIL p1_busy: got %h want 0000000f", bz);
    else n_pass++;
  endtask

  task automatic test_count_zero();
    logic [31:0] ev, bz, dn, d;
    logic        v;
    bus_write(A_COUNT, 32'd0);
    bus_write(A_CTRL, 32'h1);
    capture(6, ev, bz, dn);
    n_checks++;
    if (ev !== 32'h0) $display("FAIL c0_pulses: got %h want 00000000", ev);
    else n_pass++;
    n_checks++;
    if (dn !== 32'h3E || bz !== 32'h1)
      $display("FAIL c0_done_busy: got done %h busy %h want done 0000003e busy 00000001", dn, bz);
    else n_pass++;
    bus_read(A_EMITTED, d, v);
    n_checks++;
    if (d !== 32'd0) $display("FAIL c0_emitted: got %0d want 0", d);
    else n_pass++;
  endtask

  task automatic test_continuous_stop();
    logic [31:0] ev, bz, dn, d;
    logic        v;
    bus_write(A_PERIOD, 32'd2);
    bus_write(A_CTRL, 32'h5);
    capture(19, ev, bz, dn);
    n_checks++;
    if (ev !== 32'h0005_5555) $display("FAIL cont_pulses: got %h want 00055555", ev);
    else n_pass++;
    bus_write(A_CTRL, 32'h2);
    n_checks++;
    if ({event_active, busy} !== 2'b00)
      $display("FAIL cont_stop_outputs: got %b want 00", {event_active, busy});
    else n_pass++;
    capture(8, ev, bz, dn);
    n_checks++;
    if (ev !== 32'h0 || bz !== 32'h0 || dn !== 32'h0)
      $display("FAIL cont_after_stop: got ev %h busy %h done %h want all 0", ev, bz, dn);
    else n_pass++;
    bus_read(A_CTRL, d, v);
    n_checks++;
    if (d !== 32'h4) $display("FAIL cont_ctrl: got %h want 00000004", d);
    else n_pass++;
    bus_read(A_EMITTED, d, v);
    n_checks++;
    if (d !== 32'd10) $display("FAIL cont_emitted: got %0d want 10", d);
    else n_pass++;
    // start and stop in the same write: stop wins, nothing starts
    bus_write(A_COUNT, 32'd5);
    bus_write(A_CTRL, 32'h3);
    capture(8, ev, bz, dn);
    n_checks++;
    if (ev !== 32'h0 || bz !== 32'h0)
      $display("FAIL start_stop_same: got ev %h busy %h want 0 0", ev, bz);
    else n_pass++;
    bus_read(A_EMITTED, d, v);
    n_checks++;
    if (d !== 32'd10) $display("FAIL start_stop_emitted: got %0d want 10", d);
    else n_pass++;
  endtask

  task automatic test_rewrite_midrun();
    logic [31:0] ev, bz, dn, d, ev_tail;
    logic        v;
    bus_write(A_COUNT, 32'd2);
    bus_write(A_PERIOD, 32'd3);
    bus_write(A_CTRL, 32'h1);
    ev = '0;
    ev[0] = event_active;
    bus_write(A_COUNT, 32'd7);
    // second start while busy must be ignored
    bus_write(A_CTRL, 32'h1);
    capture(14, ev_tail, bz, dn);
    ev = ev | (ev_tail << 2);
    n_checks++;
    if (ev !== 32'h9) $display("FAIL rewrite_pulses: got %h want 00000009", ev);
    else n_pass++;
    bus_read(A_EMITTED, d, v);
    n_checks++;
    if (d !== 32'd2) $display("FAIL rewrite_emitted: got %0d want 2", d);
    else n_pass++;
    bus_read(A_COUNT, d, v);
    n_checks++;
    if (d !== 32'd7) $display("FAIL rewrite_count_reg: got %0d want 7", d);
    else n_pass++;
    bus_write(A_CTRL, 32'h1);
    capture(32, ev, bz, dn);
    n_checks++;
    if (ev !== 32'h0004_9249) $display("FAIL next_run_pulses: got %h want 00049249", ev);
    else n_pass++;
    bus_read(A_EMITTED, d, v);
    n_checks++;
    if (d !== 32'd7) $display("FAIL next_run_emitted: got %0d want 7", d);
    else n_pass++;
  endtask

  task automatic test_reset_midrun();
    logic [31:0] ev, bz, dn, d;
    logic        v;
    bus_write(A_COUNT, 32'd5);
    bus_write(A_PERIOD, 32'd4);
    bus_write(A_CTRL, 32'h1);
    n_checks++;
    if (event_active !== 1'b1) $display("FAIL midrun_pulse_seen: got %b want 1", event_active);
    else n_pass++;
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({event_active, busy, done} !== 3'b000)
      $display("FAIL async_reset_outputs: got %b want 000", {event_active, busy, done});
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    capture(8, ev, bz, dn);
    n_checks++;
    if (ev !== 32'h0 || bz !== 32'h0) $display("FAIL after_reset_quiet: got ev %h busy %h want 0 0", ev, bz);
    else n_pass++;
    bus_read(A_COUNT, d, v);
    n_checks++;
    if (d !== 32'h0) $display("FAIL after_reset_count: got %h want 00000000", d);
    else n_pass++;
    bus_read(A_EMITTED, d, v);
    n_checks++;
    if (d !== 32'h0) $display("FAIL after_reset_emitted: got %h want 00000000", d);
    else n_pass++;
  endtask

`ifdef EVENT_GENERATOR_TRIGGER_EN
  task automatic test_trigger();
    logic [31:0] ev, d;
    logic        v;
    bus_write(A_COUNT, 32'd2);
    bus_write(A_PERIOD, 32'd2);
    bus_write(A_CTRL, 32'h8);
    trigger = 1'b1;
    ev = '0;
    for (int k = 0; k < 12; k++) begin
      ev[k] = event_active;
      if (k == 2) trigger = 1'b0;
      @(negedge clk);
    end
    n_checks++;
    if (ev !== 32'h50) $display("FAIL trigger_pulses: got %h want 00000050", ev);
    else n_pass++;
    trigger = 1'b1;
    ev = '0;
    for (int k = 0; k < 12; k++) begin
      ev[k] = event_active;
      if (k == 2) trigger = 1'b0;
      @(negedge clk);
    end
    n_checks++;
    if (ev !== 32'h0) $display("FAIL trigger_no_rearm: got %h want 00000000", ev);
    else n_pass++;
    bus_read(A_CTRL, d, v);
    n_checks++;
    if (d !== 32'h2) $display("FAIL trigger_ctrl: got %h want 00000002", d);
    else n_pass++;
  endtask
`endif

  initial begin
    bus_if.req   = 1'b0;
    bus_if.we    = 1'b0;
    bus_if.addr  = 32'h0;
    bus_if.wdata = 32'h0;
`ifdef EVENT_GENERATOR_TRIGGER_EN
    trigger = 1'b0;
`endif
    rst_n = 1'b0;
    @(negedge clk);
    test_reset();
    test_arm_bit();
    test_count5_period4();
    test_back_to_back();
    test_count_zero();
    test_continuous_stop();
    test_rewrite_midrun();
    test_reset_midrun();
`ifdef EVENT_GENERATOR_TRIGGER_EN
    test_trigger();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
